// File: rtl/pong_pkg.sv
// Shared screen geometry, bounce event encodings and ball FSM states for the pong datapath.
package pong_pkg;

  localparam int SCREEN_X = 640;
  localparam int SCREEN_Y = 480;

  typedef enum logic [1:0] {
    BOUNCE_NONE   = 2'd0,
    BOUNCE_PADDLE = 2'd1,
    BOUNCE_WALL   = 2'd2,
    BOUNCE_SCORE  = 2'd3
  } bounce_e;

  typedef enum logic {
    ST_SERVE = 1'b0,
    ST_PLAY  = 1'b1
  } state_e;

endpackage

// File: rtl/ball_controller_if.sv
// Ball controller bus: frame/bounce events in, ball geometry and motion state out.
interface ball_if;

  logic       frame_tick;
  logic       enable;
  logic [1:0] bounce;
  logic [9:0] ball_pos_x;
  logic [9:0] ball_pos_y;
  logic [7:0] ball_size_x;
  logic [7:0] ball_size_y;
  logic       ball_dir_x;
  logic       ball_dir_y;
  logic       serving;
  logic [3:0] speed;

  // master drives the game events, slave is the ball controller
  modport master (
    output frame_tick, enable, bounce,
    input  ball_pos_x, ball_pos_y, ball_size_x, ball_size_y,
    input  ball_dir_x, ball_dir_y, serving, speed
  );

  modport slave (
    input  frame_tick, enable, bounce,
    output ball_pos_x, ball_pos_y, ball_size_x, ball_size_y,
    output ball_dir_x, ball_dir_y, serving, speed
  );

endinterface

// File: rtl/ball_axis.sv
// One ball axis: direction register with approach-rule flip, and a saturating position step.
module ball_axis #(
  parameter int EXTENT            = 640,
  parameter int BALL_SIZE         = 8,
  parameter bit SERVE_TOWARD_SIDE = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       flip_req,
  input  logic       step_en,
  input  logic       recentre,
  input  logic [3:0] speed,
  output logic [9:0] pos,
  output logic       dir,
  output logic       flip_taken
);

  localparam int                 POS_MAX   = EXTENT - BALL_SIZE;
  localparam int                 CENTRE    = POS_MAX / 2;
  localparam int                 HALF      = EXTENT / 2;
  localparam logic signed [10:0] POS_MAX_S = 11'(POS_MAX);

  logic [9:0] pos_q, pos_d;
  logic       dir_q, dir_d;
  logic       near_hi;
  logic       dir_new;

  function automatic logic [9:0] sat_step(input logic [9:0] p, input logic [3:0] s,
                                          input logic up);
    logic signed [10:0] sum;
    if (up) sum = $signed({1'b0, p}) + $signed({7'b0, s});
    else    sum = $signed({1'b0, p}) - $signed({7'b0, s});
    if (sum < 11'sd0)          return '0;
    else if (sum > POS_MAX_S)  return POS_MAX_S[9:0];
    else                       return sum[9:0];
  endfunction

  always_comb begin
    near_hi    = (pos_q >= 10'(HALF));
    // Only flip while still heading into the nearer wall, so a held bounce cannot re-flip.
    flip_taken = flip_req && (near_hi == dir_q);
    dir_new    = dir_q ^ flip_taken;
    pos_d      = pos_q;
    dir_d      = dir_new;
    if (recentre) begin
      pos_d = 10'(CENTRE);
      dir_d = SERVE_TOWARD_SIDE ? near_hi : dir_q;
    end else if (step_en) begin
      pos_d = sat_step(pos_q, speed, dir_new);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pos_q <= 10'(CENTRE);
      dir_q <= 1'b1;
    end else begin
      pos_q <= pos_d;
      dir_q <= dir_d;
    end
  end

  assign pos = pos_q;
  assign dir = dir_q;

endmodule

// File: rtl/ball_controller.sv
// Ball motion FSM: serve hold, play stepping and bounce handling for the pong game loop.
// Optional feature macro: BALL_SPEED_RAMP_EN (paddle hits ramp speed up to SPEED_MAX).
module ball_controller #(
  parameter int SCREEN_X    = pong_pkg::SCREEN_X,
  parameter int SCREEN_Y    = pong_pkg::SCREEN_Y,
  parameter int BALL_SIZE   = 8,
  parameter int SPEED_INIT  = 2,
  parameter int SPEED_MAX   = 8,
  parameter int SERVE_DELAY = 60
) (
  input  logic  clock,
  input  logic  reset,
  ball_if.slave bif
);

  import pong_pkg::*;

  localparam int CNT_W = $clog2(SERVE_DELAY + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       speed_q, speed_d;

  logic    play_active;
  logic    score;
  logic    flip_x_req, flip_y_req;
  logic    step_en;
  logic    flip_x_taken, flip_y_taken;
  bounce_e bounce_ev;

  always_comb begin
    bounce_ev   = bounce_e'(bif.bounce);
    state_d     = state_q;
    cnt_d       = cnt_q;
    speed_d     = speed_q;
    // Events only count in PLAY; SERVE swallows the stale score the comparator emits after recentring.
    play_active = bif.enable && (state_q == ST_PLAY);
    score       = play_active && (bounce_ev == BOUNCE_SCORE);
    flip_x_req  = play_active && (bounce_ev == BOUNCE_PADDLE);
    flip_y_req  = play_active && (bounce_ev == BOUNCE_WALL);
    step_en     = play_active && bif.frame_tick && !score;

    if (bif.enable && (state_q == ST_SERVE) && bif.frame_tick) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_d == CNT_W'(SERVE_DELAY)) state_d = ST_PLAY;
    end

    if (score) begin
      state_d = ST_SERVE;
      cnt_d   = '0;
      speed_d = 4'(SPEED_INIT);
    end

`ifdef BALL_SPEED_RAMP_EN
    if (flip_x_taken && (speed_q < 4'(SPEED_MAX))) speed_d = speed_q + 4'd1;
`endif
  end

`ifndef BALL_SPEED_RAMP_EN
  logic unused_ramp;
  assign unused_ramp = ^{flip_x_taken, 4'(SPEED_MAX)};
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_SERVE;
      cnt_q   <= '0;
      speed_q <= 4'(SPEED_INIT);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      speed_q <= speed_d;
    end
  end

  ball_axis #(
    .EXTENT            (SCREEN_X),
    .BALL_SIZE         (BALL_SIZE),
    .SERVE_TOWARD_SIDE (1'b1)
  ) u_axis_x (
    .clock      (clock),
    .reset      (reset),
    .flip_req   (flip_x_req),
    .step_en    (step_en),
    .recentre   (score),
    .speed      (speed_q),
    .pos        (bif.ball_pos_x),
    .dir        (bif.ball_dir_x),
    .flip_taken (flip_x_taken)
  );

  ball_axis #(
    .EXTENT            (SCREEN_Y),
    .BALL_SIZE         (BALL_SIZE),
    .SERVE_TOWARD_SIDE (1'b0)
  ) u_axis_y (
    .clock      (clock),
    .reset      (reset),
    .flip_req   (flip_y_req),
    .step_en    (step_en),
    .recentre   (score),
    .speed      (speed_q),
    .pos        (bif.ball_pos_y),
    .dir        (bif.ball_dir_y),
    .flip_taken (flip_y_taken)
  );

  logic unused_flip_y;
  assign unused_flip_y = flip_y_taken;

  assign bif.ball_size_x = 8'(BALL_SIZE);
  assign bif.ball_size_y = 8'(BALL_SIZE);
  assign bif.serving     = (state_q == ST_SERVE);
  assign bif.speed       = speed_q;

endmodule

// File: tb/tb_ball_controller.sv
// Randomized scoreboard bench for ball_controller against a per-cycle game-rule model.
module tb_ball_controller;

  localparam int SX = 640, SY = 480, BS = 8, S_INIT = 2, S_MAX = 8, DELAY = 60;
  localparam int X_MAX = SX - BS, Y_MAX = SY - BS;
  localparam int CX = X_MAX / 2, CY = Y_MAX / 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  ball_if bif ();

  ball_controller dut (
    .clock (clock),
    .reset (reset),
    .bif   (bif)
  );

  typedef struct {
    int x; int y; bit dx; bit dy; bit serving; int speed;
  } exp_t;

  exp_t exp_q[$];
  int   tests  = 0;
  int   failed = 0;
  bit   stim_done = 0;

  // Reference state of the game, updated once per clock from the rules of play.
  int m_x, m_y, m_speed, m_cnt;
  bit m_dx, m_dy, m_serving;

  function automatic int clamp(input int v, input int hi);
    if (v < 0)  return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic void model_step(input bit r, input bit t, input bit e, input int b);
    int s;
    if (r) begin
      m_x = CX; m_y = CY; m_dx = 1; m_dy = 1;
      m_speed = S_INIT; m_cnt = 0; m_serving = 1;
      return;
    end
    if (!e) return;
    if (m_serving) begin
      if (t) begin
        m_cnt++;
        if (m_cnt == DELAY) m_serving = 0;
      end
      return;
    end
    if (b == 3) begin
      m_dx = (m_x >= SX / 2);
      m_x = CX; m_y = CY; m_speed = S_INIT; m_cnt = 0; m_serving = 1;
      return;
    end
    s = m_speed;
    if (b == 1 && ((m_x < SX / 2 && !m_dx) || (m_x >= SX / 2 && m_dx))) begin
      m_dx = !m_dx;
`ifdef BALL_SPEED_RAMP_EN
      if (m_speed < S_MAX) m_speed++;
`endif
    end
    if (b == 2 && ((m_y < SY / 2 && !m_dy) || (m_y >= SY / 2 && m_dy))) m_dy = !m_dy;
    if (t) begin
      m_x = clamp(m_dx ? m_x + s : m_x - s, X_MAX);
      m_y = clamp(m_dy ? m_y + s : m_y - s, Y_MAX);
    end
  endfunction

  task automatic drive(input bit r, input bit t, input bit e, input int b);
    exp_t ex;
    @(negedge clock);
    reset          = r;
    bif.frame_tick = t;
    bif.enable     = e;
    bif.bounce     = 2'(b);
    model_step(r, t, e, b);
    ex = '{x: m_x, y: m_y, dx: m_dx, dy: m_dy, serving: m_serving, speed: m_speed};
    exp_q.push_back(ex);
  endtask

  // Monitor: the DUT presents a new ball state every cycle; compare it against the queued prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        tests++;
        if (int'(bif.ball_pos_x) != e.x || int'(bif.ball_pos_y) != e.y ||
            bif.ball_dir_x != e.dx || bif.ball_dir_y != e.dy ||
            bif.serving != e.serving || int'(bif.speed) != e.speed ||
            int'(bif.ball_size_x) != BS || int'(bif.ball_size_y) != BS) begin
          failed++;
          $display("FAIL ball_state t=%0t got x=%0d y=%0d dx=%0b dy=%0b srv=%0b spd=%0d sz=%0d/%0d want x=%0d y=%0d dx=%0b dy=%0b srv=%0b spd=%0d sz=%0d",
                   $time, bif.ball_pos_x, bif.ball_pos_y, bif.ball_dir_x, bif.ball_dir_y,
                   bif.serving, bif.speed, bif.ball_size_x, bif.ball_size_y,
                   e.x, e.y, e.dx, e.dy, e.serving, e.speed, BS);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t, scoreboard still had %0d entries", $time, exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int n, b;
    bif.frame_tick = 1'b0;
    bif.enable     = 1'b1;
    bif.bounce     = 2'd0;

    drive(1, 0, 1, 0);
    drive(1, 1, 1, 3);

    // Serve with pauses and stray bounces, then a long no-bounce run into both saturation limits.
    for (int i = 0; i < 75; i++) drive(0, 1, (i % 7) != 3, int'($urandom_range(0, 3)));
    for (int i = 0; i < 400; i++) drive(0, 1, 1, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 1, 1);
    for (int i = 0; i < 3; i++) drive(0, 1, 1, 2);
    drive(0, 0, 1, 3);
    drive(0, 0, 1, 3);

    for (int i = 0; i < 3000; i++) begin
      n = int'($urandom_range(0, 63));
      if (n < 4)       b = 1;
      else if (n < 8)  b = 2;
      else if (n == 8) b = 3;
      else             b = 0;
      if (i % 700 == 350) begin
        for (int k = 0; k < 3; k++) drive(0, 0, 1, 1);
      end
      drive($urandom_range(0, 999) == 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 9) != 0, b);
    end

    // Paddle-heavy burst to drive the speed ramp into its ceiling when enabled.
    for (int i = 0; i < 200; i++) drive(0, 1, 1, (i % 5 == 0) ? 1 : 0);
    drive(0, 1, 1, 3);
    drive(0, 0, 1, 0);

    @(posedge clock);
    #3;
    tests++;
    if (exp_q.size() != 0) begin
      failed++;
      $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
